// File: rtl/ram_dp_pkg.sv
// ram_dp_pkg
//   Shared constants for the ram_dp FIFO controller slice: default address
//   and data widths, the resulting FIFO depth, and the fill-count width.
package ram_dp_pkg;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEPTH          = 2 ** DEF_ADDR_WIDTH;

    // The count must be able to represent a completely full FIFO (== DEPTH),
    // which needs one bit more than a pointer.
    function automatic int count_width(input int addr_width);
        return addr_width + 1;
    endfunction

    localparam int CNT_WIDTH = count_width(DEF_ADDR_WIDTH);

endpackage

// File: rtl/ram_dp_fifo_ctrl_if.sv
// ram_dp_fifo_ctrl_if
//   User-side FIFO bus of ram_dp_fifo_ctrl.
//   master : drives push/wr_data/pop, observes read data and status
//   slave  : the controller; accepts requests, returns rd_data/rd_valid,
//            full/empty/count and the overflow/underflow pulses
interface ram_dp_fifo_ctrl_if #(
    parameter int ADDR_WIDTH = ram_dp_pkg::DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = ram_dp_pkg::DEF_DATA_WIDTH
) ();

    logic                  push;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  pop;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic [ram_dp_pkg::count_width(ADDR_WIDTH)-1:0] count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output push, wr_data, pop,
        input  rd_data, rd_valid, full, empty, count, overflow, underflow
    );

    modport slave (
        input  push, wr_data, pop,
        output rd_data, rd_valid, full, empty, count, overflow, underflow
    );

endinterface

// File: rtl/ram_dp_fifo_ptr.sv
// ram_dp_fifo_ptr
//   Wrapping pointer register. Advances by one when en is high and wraps
//   from 2**WIDTH-1 back to 0 through natural overflow.
//   clk : clock, rising edge
//   rst : synchronous, active-high reset (pointer -> 0)
//   en  : advance the pointer this edge
//   ptr : current pointer value
module ram_dp_fifo_ptr
    import ram_dp_pkg::*;
#(
    parameter int WIDTH = DEF_ADDR_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] ptr
);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of the others, avoiding simulation races.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/ram_dp_fifo_ctrl.sv
// ram_dp_fifo_ctrl
//   Turns an external dual-port ram_dp into a 2**ADDR_WIDTH-entry FIFO.
//   Port 0 is used write-only, port 1 read-only.
//   clk, rst        : clock and synchronous active-high reset
//   fifo            : user-side FIFO bus (slave modport)
//   address_0..oe_0 : RAM port 0 (write) controls and write data
//   address_1..oe_1 : RAM port 1 (read) controls; data_1 is the registered
//                     RAM read data
//   Read latency: pop accepted at edge N -> rd_valid/rd_data after edge N+2.
module ram_dp_fifo_ctrl
    import ram_dp_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    ram_dp_fifo_ctrl_if.slave     fifo,
    output logic [ADDR_WIDTH-1:0] address_0,
    output logic [DATA_WIDTH-1:0] data_0,
    output logic                  cs_0,
    output logic                  we_0,
    output logic                  oe_0,
    output logic [ADDR_WIDTH-1:0] address_1,
    input  logic [DATA_WIDTH-1:0] data_1,
    output logic                  cs_1,
    output logic                  we_1,
    output logic                  oe_1
);

    localparam logic [ADDR_WIDTH:0] FULL_LEVEL = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic                  push_ok;
    logic                  pop_ok;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count_next;
    // [0]: RAM address presented, [1]: RAM output register holds the word
    logic [1:0]            valid_pipe;

    // At full a simultaneous pop is still accepted and the push is rejected;
    // at empty the push is accepted and the pop rejected. Both fall out of
    // gating each request only by its own flag.
    assign push_ok = fifo.push && !fifo.full;
    assign pop_ok  = fifo.pop  && !fifo.empty;

    assign oe_0 = 1'b0;
    assign we_1 = 1'b0;

    ram_dp_fifo_ptr #(.WIDTH(ADDR_WIDTH)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .en  (push_ok),
        .ptr (wr_ptr)
    );

    ram_dp_fifo_ptr #(.WIDTH(ADDR_WIDTH)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .en  (pop_ok),
        .ptr (rd_ptr)
    );

    always_comb begin
        count_next = fifo.count;
        if (push_ok && !pop_ok) begin
            count_next = fifo.count + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_next = fifo.count - 1'b1;
        end
    end

    // Flags are derived from count_next so full/empty always agree with
    // count in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            address_0      <= '0;
            data_0         <= '0;
            cs_0           <= 1'b0;
            we_0           <= 1'b0;
            address_1      <= '0;
            cs_1           <= 1'b0;
            oe_1           <= 1'b0;
            valid_pipe     <= '0;
            fifo.rd_data   <= '0;
            fifo.rd_valid  <= 1'b0;
            fifo.count     <= '0;
            fifo.full      <= 1'b0;
            fifo.empty     <= 1'b1;
            fifo.overflow  <= 1'b0;
            fifo.underflow <= 1'b0;
        end else begin
            cs_0 <= push_ok;
            we_0 <= push_ok;
            if (push_ok) begin
                address_0 <= wr_ptr;
                data_0    <= fifo.wr_data;
            end

            cs_1 <= 1'b1;
            oe_1 <= 1'b1;
            if (pop_ok) begin
                address_1 <= rd_ptr;
            end

            valid_pipe    <= {valid_pipe[0], pop_ok};
            fifo.rd_valid <= valid_pipe[1];
            if (valid_pipe[1]) begin
                fifo.rd_data <= data_1;
            end

            fifo.count     <= count_next;
            fifo.full      <= (count_next == FULL_LEVEL);
            fifo.empty     <= (count_next == '0);
            fifo.overflow  <= fifo.push && fifo.full;
            fifo.underflow <= fifo.pop && fifo.empty;
        end
    end

endmodule

// File: tb/tb_ram_dp_fifo_ctrl.sv
// tb_ram_dp_fifo_ctrl
//   Self-checking bench for ram_dp_fifo_ctrl with a behavioural ram_dp model.
//   The reference is a queue-based FIFO plus a list of expected read returns.
module tb_ram_dp_fifo_ctrl;
    import ram_dp_pkg::*;

    localparam int AW = DEF_ADDR_WIDTH;
    localparam int DW = DEF_DATA_WIDTH;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rd_exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] address_0, address_1;
    logic [DW-1:0] data_0;
    logic [DW-1:0] data_1 = '0;
    logic          cs_0, we_0, oe_0, cs_1, we_1, oe_1;

    ram_dp_fifo_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) fifo_bus ();

    ram_dp_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo      (fifo_bus),
        .address_0 (address_0),
        .data_0    (data_0),
        .cs_0      (cs_0),
        .we_0      (we_0),
        .oe_0      (oe_0),
        .address_1 (address_1),
        .data_1    (data_1),
        .cs_1      (cs_1),
        .we_1      (we_1),
        .oe_1      (oe_1)
    );

    always #5 clk = ~clk;

    // Behavioural ram_dp: synchronous write on port 0, registered read on port 1.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (cs_0 && we_0) mem[address_0] <= data_0;
        if (cs_1 && oe_1 && !we_1) data_1 <= mem[address_1];
    end

    // Reference model state
    logic [DW-1:0] q[$];
    rd_exp_t       pend[$];
    logic [AW-1:0] m_wr;
    logic [AW-1:0] m_rd;
    int            cyc;
    int            errors;
    int            checks;

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic model_clear();
        q.delete();
        pend.delete();
        m_wr = '0;
        m_rd = '0;
    endtask

    // One clock of stimulus; the model decides acceptance from its own fill
    // level and every observable output is compared after the edge.
    task automatic step(input bit p, input logic [DW-1:0] d, input bit r);
        bit            m_full, m_empty, p_ok, r_ok;
        logic [DW-1:0] popped;
        logic [AW-1:0] exp_a0, exp_a1;
        rd_exp_t       e;
        bit            exp_rv;
        fifo_bus.push    = p;
        fifo_bus.wr_data = d;
        fifo_bus.pop     = r;
        m_full  = (q.size() == DEPTH);
        m_empty = (q.size() == 0);
        p_ok = p && !m_full;
        r_ok = r && !m_empty;
        exp_a0 = m_wr;
        exp_a1 = m_rd;
        popped = '0;
        if (r_ok) begin
            popped = q.pop_front();
            m_rd   = m_rd + 1'b1;
        end
        if (p_ok) begin
            q.push_back(d);
            m_wr = m_wr + 1'b1;
        end
        tick();
        if (r_ok) begin
            e.due  = cyc + 2;
            e.data = popped;
            pend.push_back(e);
        end
        fifo_bus.push = 1'b0;
        fifo_bus.pop  = 1'b0;

        checks++;
        if (fifo_bus.count !== CNT_WIDTH'(q.size())) begin
            errors++; $display("FAIL count: got %0d want %0d (cycle %0d)", fifo_bus.count, q.size(), cyc);
        end
        checks++;
        if (fifo_bus.full !== (q.size() == DEPTH)) begin
            errors++; $display("FAIL full: got %0b want %0b (cycle %0d)", fifo_bus.full, q.size() == DEPTH, cyc);
        end
        checks++;
        if (fifo_bus.empty !== (q.size() == 0)) begin
            errors++; $display("FAIL empty: got %0b want %0b (cycle %0d)", fifo_bus.empty, q.size() == 0, cyc);
        end
        checks++;
        if (fifo_bus.overflow !== (p && m_full)) begin
            errors++; $display("FAIL overflow: got %0b want %0b (cycle %0d)", fifo_bus.overflow, p && m_full, cyc);
        end
        checks++;
        if (fifo_bus.underflow !== (r && m_empty)) begin
            errors++; $display("FAIL underflow: got %0b want %0b (cycle %0d)", fifo_bus.underflow, r && m_empty, cyc);
        end
        checks++;
        if (cs_0 !== p_ok || we_0 !== p_ok) begin
            errors++; $display("FAIL wr_strobe: got cs_0=%0b we_0=%0b want %0b (cycle %0d)", cs_0, we_0, p_ok, cyc);
        end
        if (p_ok) begin
            checks++;
            if (address_0 !== exp_a0 || data_0 !== d) begin
                errors++; $display("FAIL wr_port: got addr=%0h data=%0h want addr=%0h data=%0h", address_0, data_0, exp_a0, d);
            end
        end
        if (r_ok) begin
            checks++;
            if (address_1 !== exp_a1) begin
                errors++; $display("FAIL rd_addr: got %0h want %0h (cycle %0d)", address_1, exp_a1, cyc);
            end
        end
        exp_rv = (pend.size() > 0) && (pend[0].due == cyc);
        checks++;
        if (fifo_bus.rd_valid !== exp_rv) begin
            errors++; $display("FAIL rd_valid: got %0b want %0b (cycle %0d)", fifo_bus.rd_valid, exp_rv, cyc);
        end
        if (exp_rv) begin
            e = pend.pop_front();
            checks++;
            if (fifo_bus.rd_data !== e.data) begin
                errors++; $display("FAIL rd_data: got %0h want %0h (cycle %0d)", fifo_bus.rd_data, e.data, cyc);
            end
        end
    endtask

    task automatic drain_reads();
        repeat (3) step(1'b0, '0, 1'b0);
        checks++;
        if (pend.size() != 0) begin
            errors++; $display("FAIL drain: got %0d reads outstanding want 0", pend.size());
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        fifo_bus.push = 1'b0;
        fifo_bus.pop  = 1'b0;
        repeat (n) tick();
        model_clear();
        rst = 1'b0;
        step(1'b0, '0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        fifo_bus.push = 1'b0;
        fifo_bus.pop  = 1'b0;
        fifo_bus.wr_data = '0;
        repeat (2) tick();
        checks++;
        if ({cs_0, we_0, oe_0, cs_1, we_1, oe_1} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl: got %06b want 000000", {cs_0, we_0, oe_0, cs_1, we_1, oe_1});
        end
        checks++;
        if (fifo_bus.empty !== 1'b1 || fifo_bus.full !== 1'b0 || fifo_bus.count !== '0) begin
            errors++; $display("FAIL reset_status: got empty=%0b full=%0b count=%0d want 1 0 0", fifo_bus.empty, fifo_bus.full, fifo_bus.count);
        end
        checks++;
        if (fifo_bus.rd_valid !== 1'b0 || fifo_bus.rd_data !== '0 || fifo_bus.overflow !== 1'b0 || fifo_bus.underflow !== 1'b0) begin
            errors++; $display("FAIL reset_rd: got rv=%0b rd=%0h ovf=%0b udf=%0b want all 0", fifo_bus.rd_valid, fifo_bus.rd_data, fifo_bus.overflow, fifo_bus.underflow);
        end
        checks++;
        if (address_0 !== '0 || address_1 !== '0 || data_0 !== '0) begin
            errors++; $display("FAIL reset_addr: got a0=%0h a1=%0h d0=%0h want 0", address_0, address_1, data_0);
        end
        model_clear();
        rst = 1'b0;
        step(1'b0, '0, 1'b0);
        checks++;
        if (cs_1 !== 1'b1 || oe_1 !== 1'b1 || we_1 !== 1'b0 || oe_0 !== 1'b0) begin
            errors++; $display("FAIL port1_enable: got cs_1=%0b oe_1=%0b we_1=%0b oe_0=%0b want 1 1 0 0", cs_1, oe_1, we_1, oe_0);
        end
    endtask

    task automatic test_basic();
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        step(1'b1, 8'h33, 1'b0);
        repeat (3) step(1'b0, '0, 1'b1);
        drain_reads();
    endtask

    task automatic test_full_overflow();
        for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(i), 1'b0);
        checks++;
        if (fifo_bus.full !== 1'b1 || fifo_bus.count !== CNT_WIDTH'(DEPTH)) begin
            errors++; $display("FAIL full_level: got full=%0b count=%0d want 1 %0d", fifo_bus.full, fifo_bus.count, DEPTH);
        end
        step(1'b1, 8'hEE, 1'b0);
        checks++;
        if (fifo_bus.overflow !== 1'b1 || fifo_bus.count !== CNT_WIDTH'(DEPTH)) begin
            errors++; $display("FAIL overflow_pulse: got ovf=%0b count=%0d want 1 %0d", fifo_bus.overflow, fifo_bus.count, DEPTH);
        end
        step(1'b0, '0, 1'b0);
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1);
        drain_reads();
        checks++;
        if (fifo_bus.empty !== 1'b1) begin
            errors++; $display("FAIL drained_empty: got %0b want 1", fifo_bus.empty);
        end
    endtask

    task automatic test_wrap();
        do_reset(2);
        for (int i = 0; i < 250; i++) step(1'b1, DW'($urandom), 1'b0);
        for (int i = 0; i < 250; i++) step(1'b0, '0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, DW'(8'hA0 + i), 1'b0);
            if (i == 6) begin
                checks++;
                if (address_0 !== '0) begin
                    errors++; $display("FAIL wr_wrap: got address_0=%0h want 0", address_0);
                end
            end
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b0, '0, 1'b1);
            if (i == 6) begin
                checks++;
                if (address_1 !== '0) begin
                    errors++; $display("FAIL rd_wrap: got address_1=%0h want 0", address_1);
                end
            end
        end
        drain_reads();
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 5; i++) step(1'b1, DW'(8'h50 + i), 1'b0);
        step(1'b1, 8'h55, 1'b1);
        checks++;
        if (fifo_bus.count !== CNT_WIDTH'(5)) begin
            errors++; $display("FAIL push_pop_count: got %0d want 5", fifo_bus.count);
        end
        repeat (6) step(1'b0, '0, 1'b1);
        drain_reads();
        step(1'b1, 8'h66, 1'b1);
        checks++;
        if (fifo_bus.underflow !== 1'b1 || fifo_bus.count !== CNT_WIDTH'(1)) begin
            errors++; $display("FAIL empty_push_pop: got udf=%0b count=%0d want 1 1", fifo_bus.underflow, fifo_bus.count);
        end
        step(1'b0, '0, 1'b1);
        drain_reads();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            int thr;
            thr = (i < 300) ? 70 : 30;
            step(($urandom_range(0, 99) < thr), DW'($urandom), ($urandom_range(0, 99) >= thr));
        end
        while (q.size() > 0) step(1'b0, '0, 1'b1);
        drain_reads();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) step(1'b1, DW'(8'hC0 + i), 1'b0);
        step(1'b0, '0, 1'b1);
        rst = 1'b1;
        tick();
        model_clear();
        checks++;
        if (fifo_bus.count !== '0 || fifo_bus.empty !== 1'b1 || fifo_bus.rd_valid !== 1'b0) begin
            errors++; $display("FAIL mid_reset: got count=%0d empty=%0b rv=%0b want 0 1 0", fifo_bus.count, fifo_bus.empty, fifo_bus.rd_valid);
        end
        rst = 1'b0;
        repeat (4) step(1'b0, '0, 1'b0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        cyc    = 0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        model_clear();
        test_reset();
        test_basic();
        test_full_overflow();
        test_wrap();
        test_simultaneous();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
